mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory-access stage of the 5-stage RV32 pipeline. Sits between the EX/MEM pipeline register and the MEM/WB register.
- Drives a variable-latency, word-wide data-memory port through a req/ack handshake.
- Performs byte-lane alignment and sign/zero extension for loads and stores.
- Stalls the upstream pipeline while an access is outstanding.
- Passes non-memory instructions through combinationally with zero added latency.

Parameters:
TIMEOUT_CYCLES, 255, BUSY cycles without mem_ack_i before the access is aborted; range 1..255.
CNT_W, 8, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous, active-high reset
valid_i  in  1  EX/MEM slot holds a real instruction
MemRead_i  in  1  load
MemWrite_i  in  1  store
funct3_i  in  3  access size/sign (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use 000/001/010)
ALUResult_i  in  32  effective address, or ALU result for non-memory ops
wdata_i  in  32  store data (rs2)
RDaddr_i  in  5  destination register
RegWrite_i  in  1  register write enable
MemtoReg_i  in  1  writeback selects memory data
RDaddr_o  out  5  to MEM/WB
ALUResult_o  out  32  to MEM/WB
mem_o  out  32  extended load data to MEM/WB
RegWrite_o  out  1  to MEM/WB
MemtoReg_o  out  1  to MEM/WB
stall_o  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle
err_o  out  1  one-cycle pulse: misaligned, illegal funct3, or timeout
mem_req_o  out  1  memory request, registered
mem_we_o  out  1  1 = write
mem_addr_o  out  32  word address; bits [1:0] forced to 0
mem_be_o  out  4  byte enables
mem_wdata_o  out  32  lane-aligned store data
mem_ack_i  in  1  access complete; rdata valid this cycle
mem_rdata_i  in  32  read word

Behaviour:
- Memory op: valid_i & (MemRead_i | MemWrite_i). If both MemRead_i and MemWrite_i are set, treat the access as a store.
- Fault conditions (combinational):
  - illegal: funct3 not in the legal set for the op.
  - misaligned: halfword with addr[0] = 1, or word with addr[1:0] != 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Non-memory op or invalid slot: outputs pass through combinationally from the inputs; mem_o = 0; stall_o = 0.
  - Memory op with a fault: no request; stall_o = 0; err_o = 1; RegWrite_o = 0; remaining fields pass through.
  - Memory op with no fault: stall_o = 1 and RegWrite_o = 0 (bubble). At the next edge, latch address, be, wdata, we, funct3, RDaddr, RegWrite and MemtoReg; set mem_req_o = 1; clear the counter; go to BUSY.
- BUSY:
  - stall_o = 1; RegWrite_o = 0.
  - mem_req_o and all mem_* outputs stay stable until mem_ack_i.
  - On mem_ack_i: capture the extended mem_rdata_i (loads only; stores capture 0); mem_req_o = 0; go to DONE.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES-1 with no ack: mem_req_o = 0; mark timeout; go to DONE.
- DONE:
  - stall_o = 0. Outputs come from the latched fields, mem_o = captured data.
  - Timeout: err_o = 1 and RegWrite_o = 0.
  - Upstream advances at this edge. Next state is always IDLE, so the held instruction is never reissued.
- Minimum in-stage latency for a memory op: 3 cycles (IDLE, BUSY with same-cycle ack, DONE). Each added wait cycle adds one.
- Store lanes (a = addr[1:0]):
  - sb: be = 1 << a; wdata = byte replicated ×4.
  - sh: be = 0011 when a[1] = 0, else 1100; wdata = halfword replicated ×2.
  - sw: be = 1111.
- Load extraction: select the byte or halfword lane by addr; lb/lh sign-extend, lbu/lhu zero-extend.
- mem_be_o = 0000 and mem_we_o = 0 whenever mem_req_o = 0.
- Reset (rst_i, any state, including mid-BUSY):
  - State = IDLE; mem_req_o = 0; counter = 0; latched fields = 0.
  - Registered outputs read 0, so stall_o = 0 and err_o = 0 unless the current inputs drive them.
  - An ack arriving after reset is ignored; IDLE always ignores mem_ack_i.

Decomposition:
- Shared package (cpu_pkg): funct3 load/store encodings, FSM state enum, BE constants.
- Sub-module mem_lane_align: combinational store-lane/BE generation and load extract/extend. It is reused by any future cache.

Test Plan:
- add x5 (ALUResult 0x0000_1234, RegWrite 1, no mem op) -> same-cycle passthrough; stall_o 0; mem_req_o never 1.
- lw @0x100, ack on the first BUSY cycle, rdata 0xDEAD_BEEF -> stall_o high for 2 cycles; then DONE with mem_o = 0xDEAD_BEEF, RegWrite_o = 1; 3 cycles total.
- lb/lbu @0x103, rdata 0x80xx_xxxx, ack after 4 waits -> mem_o = 0xFFFF_FF80 (lb) / 0x0000_0080 (lbu); stall_o for 6 cycles.
- sh @0x202 data 0x0000_ABCD -> mem_be_o = 1100, mem_wdata_o = 0xABCD_ABCD, mem_we_o = 1, mem_addr_o = 0x200.
- lw @0x101 -> err_o pulse, no mem_req_o, RegWrite_o = 0, stall_o 0. Separately: no ack for 255 BUSY cycles -> err_o in DONE, RegWrite_o = 0, then IDLE.
- rst_i asserted in BUSY before ack, then ack arrives -> mem_req_o 0 the next cycle, state IDLE, ack ignored, stall_o 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared RV32 memory-access definitions: funct3 encodings, byte-enable constants, stage FSM and latched request.
// Latency: n/a (types, constants and pure combinational helpers only).
// Backpressure: n/a.
package cpu_pkg;

    // Load/store size and sign encodings (stores use only the first three)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte-enable patterns
    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_ALL     = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    // Fields captured when an access is launched and held until writeback
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_to_reg;
    } mem_lat_t;

    // funct3 outside the legal set for a load or a store
    function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
        logic ok;
        if (is_store) ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else          ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                           (f3 == F3_BU) || (f3 == F3_HU);
        return !ok;
    endfunction

    // Halfword on an odd address, or word not on a 4-byte boundary
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic mis;
        case (f3)
            F3_H, F3_HU: mis = a[0];
            F3_W:        mis = (a != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store data replication + byte enables, and load lane extract with sign/zero extension.
// Latency: purely combinational, zero cycles.
// Backpressure: none; store and load paths are independent and always valid.
module mem_lane_align
    import cpu_pkg::*;
(
    input  logic [2:0]  st_funct3_i,
    input  logic [1:0]  st_addr_lo_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_data_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store path: replicate the datum across the word and enable the addressed lanes
    always_comb begin
        st_be_o   = BE_NONE;
        st_data_o = 32'h0;
        case (st_funct3_i)
            F3_B: begin
                st_be_o   = BE_BYTE0 << st_addr_lo_i;
                st_data_o = {4{st_data_i[7:0]}};
            end
            F3_H: begin
                st_be_o   = st_addr_lo_i[1] ? BE_HI_HALF : BE_LO_HALF;
                st_data_o = {2{st_data_i[15:0]}};
            end
            F3_W: begin
                st_be_o   = BE_ALL;
                st_data_o = st_data_i;
            end
            default: begin
                st_be_o   = BE_NONE;
                st_data_o = 32'h0;
            end
        endcase
    end

    // Load path: pick the addressed lane, then extend according to funct3
    always_comb begin
        ld_byte = 8'h0;
        case (ld_addr_lo_i)
            2'd0:    ld_byte = ld_word_i[7:0];
            2'd1:    ld_byte = ld_word_i[15:8];
            2'd2:    ld_byte = ld_word_i[23:16];
            default: ld_byte = ld_word_i[31:24];
        endcase
        ld_half = ld_addr_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

        ld_data_o = ld_word_i;
        case (ld_funct3_i)
            F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
            F3_BU:   ld_data_o = {24'h0, ld_byte};
            F3_HU:   ld_data_o = {16'h0, ld_half};
            default: ld_data_o = ld_word_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32 MEM stage: drives a req/ack data-memory port, aligns store lanes, extends load data, passes other ops through.
// Latency: non-memory ops 0 cycles; memory ops 3 cycles minimum (IDLE, BUSY, DONE) plus one per ack wait cycle.
// Backpressure: stall_o freezes upstream from launch until DONE; a BUSY access gives up after TIMEOUT_CYCLES without ack.
module mem_stage
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] ALUResult_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  RDaddr_i,
    input  logic        RegWrite_i,
    input  logic        MemtoReg_i,
    output logic [4:0]  RDaddr_o,
    output logic [31:0] ALUResult_o,
    output logic [31:0] mem_o,
    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic        stall_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    mem_state_t       state_q, state_d;
    mem_lat_t         lat_q, lat_d;
    logic             req_q, req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             tmo_q, tmo_d;

    logic        is_mem, is_store, fault, go, at_limit;
    logic [3:0]  st_be;
    logic [31:0] st_data, ld_data;

    // Decode the incoming slot; a slot flagged both read and write is a store
    always_comb begin
        is_mem   = valid_i & (MemRead_i | MemWrite_i);
        is_store = MemWrite_i;
        fault    = is_mem & (f3_illegal(is_store, funct3_i) |
                             f3_misaligned(funct3_i, ALUResult_i[1:0]));
        go       = is_mem & ~fault;
        at_limit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    mem_lane_align u_lane_align (
        .st_funct3_i  (funct3_i),
        .st_addr_lo_i (ALUResult_i[1:0]),
        .st_data_i    (wdata_i),
        .st_be_o      (st_be),
        .st_data_o    (st_data),
        .ld_funct3_i  (lat_q.funct3),
        .ld_addr_lo_i (lat_q.addr[1:0]),
        .ld_word_i    (mem_rdata_i),
        .ld_data_o    (ld_data)
    );

    // State and datapath registers, all cleared by synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            lat_q   <= '0;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= 32'h0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state: launch from IDLE, leave BUSY on ack or timeout, DONE always returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (go) state_d = ST_BUSY;
            ST_BUSY: if (mem_ack_i || at_limit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: capture the request at launch, hold it while BUSY, capture read data on ack
    always_comb begin
        lat_d   = lat_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        tmo_d   = tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    lat_d.addr       = ALUResult_i;
                    // Loads read the whole word; lane selection happens on the returned data
                    lat_d.be         = is_store ? st_be : BE_ALL;
                    lat_d.wdata      = is_store ? st_data : 32'h0;
                    lat_d.we         = is_store;
                    lat_d.funct3     = funct3_i;
                    lat_d.rd         = RDaddr_i;
                    lat_d.reg_write  = RegWrite_i;
                    lat_d.mem_to_reg = MemtoReg_i;
                    req_d            = 1'b1;
                    cnt_d            = '0;
                    rdata_d          = 32'h0;
                    tmo_d            = 1'b0;
                end
            end
            ST_BUSY: begin
                if (mem_ack_i) begin
                    rdata_d = lat_q.we ? 32'h0 : ld_data;
                    req_d   = 1'b0;
                end else if (at_limit) begin
                    req_d = 1'b0;
                    tmo_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                req_d = 1'b0;
            end
        endcase
    end

    // Pipeline-facing outputs: passthrough in IDLE, bubble while BUSY, latched result in DONE
    always_comb begin
        RDaddr_o    = RDaddr_i;
        ALUResult_o = ALUResult_i;
        mem_o       = 32'h0;
        RegWrite_o  = RegWrite_i;
        MemtoReg_o  = MemtoReg_i;
        stall_o     = 1'b0;
        err_o       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Any memory op suppresses the write here: faulting ops never write, good ops write from DONE
                RegWrite_o = RegWrite_i & ~is_mem;
                stall_o    = go;
                err_o      = fault;
            end
            ST_BUSY: begin
                RDaddr_o    = lat_q.rd;
                ALUResult_o = lat_q.addr;
                MemtoReg_o  = lat_q.mem_to_reg;
                RegWrite_o  = 1'b0;
                stall_o     = 1'b1;
            end
            ST_DONE: begin
                RDaddr_o    = lat_q.rd;
                ALUResult_o = lat_q.addr;
                MemtoReg_o  = lat_q.mem_to_reg;
                mem_o       = rdata_q;
                RegWrite_o  = lat_q.reg_write & ~tmo_q;
                err_o       = tmo_q;
            end
            default: begin
                stall_o = 1'b0;
            end
        endcase
    end

    // Memory port: request and payload are registered; enables are masked whenever no request is open
    always_comb begin
        mem_req_o   = req_q;
        mem_we_o    = req_q & lat_q.we;
        mem_be_o    = req_q ? lat_q.be : BE_NONE;
        mem_addr_o  = {lat_q.addr[31:2], 2'b00};
        mem_wdata_o = lat_q.wdata;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized and directed bench for mem_stage against a transaction-level reference model.
// Latency: model predicts the cycle on which each access is in IDLE, BUSY or DONE.
// Backpressure: bench holds the slot stable while a stall is expected, as frozen upstream stages would.
module tb_mem_stage;

    localparam int TMO = 255;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        MemRead_i = 1'b0;
    logic        MemWrite_i = 1'b0;
    logic [2:0]  funct3_i = 3'd0;
    logic [31:0] ALUResult_i = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic [4:0]  RDaddr_i = 5'd0;
    logic        RegWrite_i = 1'b0;
    logic        MemtoReg_i = 1'b0;
    logic [4:0]  RDaddr_o;
    logic [31:0] ALUResult_o;
    logic [31:0] mem_o;
    logic        RegWrite_o;
    logic        MemtoReg_o;
    logic        stall_o;
    logic        err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    mem_stage #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .funct3_i    (funct3_i),
        .ALUResult_i (ALUResult_i),
        .wdata_i     (wdata_i),
        .RDaddr_i    (RDaddr_i),
        .RegWrite_i  (RegWrite_i),
        .MemtoReg_i  (MemtoReg_i),
        .RDaddr_o    (RDaddr_o),
        .ALUResult_o (ALUResult_o),
        .mem_o       (mem_o),
        .RegWrite_o  (RegWrite_o),
        .MemtoReg_o  (MemtoReg_o),
        .stall_o     (stall_o),
        .err_o       (err_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_be_o    (mem_be_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference rules, written as plain arithmetic on sizes and offsets
    function automatic bit ref_legal(input bit st, input int f3);
        if (st) return (f3 == 0) || (f3 == 1) || (f3 == 2);
        return (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    endfunction

    function automatic logic [31:0] ref_load(input int f3, input int a, input logic [31:0] word);
        logic [31:0] sh, v;
        sh = word >> (8 * a);
        case (f3)
            0: begin v = sh & 32'hFF;   if (v >= 32'd128)   v = v + 32'hFFFF_FF00; end
            1: begin v = sh & 32'hFFFF; if (v >= 32'd32768) v = v + 32'hFFFF_0000; end
            4: v = sh & 32'hFF;
            5: v = sh & 32'hFFFF;
            default: v = word;
        endcase
        return v;
    endfunction

    // One instruction through the stage; waits < 0 means the memory never acks
    task automatic do_op(input logic vld, input logic rd_en, input logic wr_en, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                         input logic rw, input logic m2r, input int waits, input logic [31:0] rdata);
        bit          is_mem, st, flt;
        int          a, f, size, nbusy;
        logic [31:0] exp_be, exp_wd, exp_mem;
        bit          ack;

        @(negedge clk_i);
        valid_i = vld; MemRead_i = rd_en; MemWrite_i = wr_en; funct3_i = f3;
        ALUResult_i = addr; wdata_i = wd; RDaddr_i = rd; RegWrite_i = rw; MemtoReg_i = m2r;
        mem_ack_i = 1'b0; mem_rdata_i = $urandom;
        #1;
        is_mem = vld && (rd_en || wr_en);
        st     = wr_en;
        a      = int'(addr % 4);
        f      = int'(f3);
        size   = 1 << (f % 4);
        flt    = is_mem && (!ref_legal(st, f) || ((a % size) != 0));

        chk("pass_rd", 32'(RDaddr_o), 32'(rd));
        chk("pass_alu", ALUResult_o, addr);
        chk("pass_m2r", 32'(MemtoReg_o), 32'(m2r));
        chk("idle_mem_o", mem_o, 32'h0);
        chk("idle_req", 32'(mem_req_o), 32'h0);
        chk("idle_be", 32'(mem_be_o), 32'h0);
        chk("idle_stall", 32'(stall_o), 32'(is_mem && !flt));
        chk("idle_err", 32'(err_o), 32'(flt));
        chk("idle_rw", 32'(RegWrite_o), 32'(rw && !is_mem));
        if (!is_mem || flt) return;

        if (st) begin
            case (f)
                0:       begin exp_be = 32'd1 << a; exp_wd = (wd & 32'hFF) * 32'h0101_0101; end
                1:       begin exp_be = 32'd3 << a; exp_wd = (wd & 32'hFFFF) * 32'h0001_0001; end
                default: begin exp_be = 32'd15;     exp_wd = wd; end
            endcase
            exp_mem = 32'h0;
        end else begin
            exp_be  = 32'd15;
            exp_wd  = 32'h0;
            exp_mem = ref_load(f, a, rdata);
        end

        nbusy = (waits < 0) ? TMO : waits + 1;
        for (int c = 1; c <= nbusy; c++) begin
            @(negedge clk_i);
            ack         = (waits >= 0) && (c == nbusy);
            mem_ack_i   = ack;
            mem_rdata_i = ack ? rdata : $urandom;
            #1;
            chk("busy_stall", 32'(stall_o), 32'h1);
            chk("busy_rw", 32'(RegWrite_o), 32'h0);
            chk("busy_err", 32'(err_o), 32'h0);
            chk("busy_req", 32'(mem_req_o), 32'h1);
            chk("busy_we", 32'(mem_we_o), 32'(st));
            chk("busy_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
            chk("busy_be", 32'(mem_be_o), exp_be);
            chk("busy_wdata", mem_wdata_o, exp_wd);
        end

        @(negedge clk_i);
        mem_ack_i = 1'b0;
        #1;
        chk("done_stall", 32'(stall_o), 32'h0);
        chk("done_err", 32'(err_o), 32'(waits < 0));
        chk("done_rw", 32'(RegWrite_o), 32'(rw && (waits >= 0)));
        chk("done_rd", 32'(RDaddr_o), 32'(rd));
        chk("done_alu", ALUResult_o, addr);
        chk("done_m2r", 32'(MemtoReg_o), 32'(m2r));
        if (waits >= 0) chk("done_mem_o", mem_o, exp_mem);
        chk("done_req", 32'(mem_req_o), 32'h0);
        chk("done_be", 32'(mem_be_o), 32'h0);
        chk("done_we", 32'(mem_we_o), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3;
        logic        rd_en, wr_en, vld;
        int          kind;
        logic [2:0]  legal_f3 [5];
        legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
        legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;

        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        chk("rst_stall", 32'(stall_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_req", 32'(mem_req_o), 32'h0);
        chk("rst_be", 32'(mem_be_o), 32'h0);
        chk("rst_we", 32'(mem_we_o), 32'h0);
        chk("rst_mem_o", mem_o, 32'h0);
        rst_i = 1'b0;

        // Directed cases
        do_op(1, 0, 0, 3'd0, 32'h0000_1234, 32'h0, 5'd5, 1, 0, 0, 32'h0);          // add x5
        do_op(1, 1, 0, 3'd2, 32'h0000_0100, 32'h0, 5'd6, 1, 1, 0, 32'hDEAD_BEEF);  // lw, ack first BUSY
        do_op(1, 1, 0, 3'd0, 32'h0000_0103, 32'h0, 5'd7, 1, 1, 4, 32'h8012_3456);  // lb, 4 waits
        do_op(1, 1, 0, 3'd4, 32'h0000_0103, 32'h0, 5'd8, 1, 1, 4, 32'h8012_3456);  // lbu, 4 waits
        do_op(1, 0, 1, 3'd1, 32'h0000_0202, 32'h0000_ABCD, 5'd0, 0, 0, 1, 32'h0);  // sh
        do_op(1, 0, 1, 3'd0, 32'h0000_0301, 32'h1234_56A5, 5'd0, 0, 0, 0, 32'h0);  // sb lane 1
        do_op(1, 1, 1, 3'd2, 32'h0000_0400, 32'hCAFE_F00D, 5'd9, 0, 0, 2, 32'h0);  // both set -> store
        do_op(1, 1, 0, 3'd2, 32'h0000_0101, 32'h0, 5'd9, 1, 1, 0, 32'h0);          // misaligned lw
        do_op(1, 1, 0, 3'd3, 32'h0000_0100, 32'h0, 5'd9, 1, 1, 0, 32'h0);          // illegal load funct3
        do_op(1, 0, 1, 3'd4, 32'h0000_0100, 32'h0, 5'd0, 0, 0, 0, 32'h0);          // illegal store funct3
        do_op(0, 1, 0, 3'd2, 32'h0000_0100, 32'h0, 5'd3, 1, 1, 0, 32'h0);          // invalid slot
        do_op(1, 1, 0, 3'd5, 32'h0000_0502, 32'h0, 5'd10, 1, 1, -1, 32'h0);        // lhu timeout
        do_op(1, 0, 0, 3'd0, 32'h0000_0042, 32'h0, 5'd11, 1, 0, 0, 32'h0);         // back in IDLE

        // Reset in the middle of BUSY, then a stale ack
        @(negedge clk_i);
        valid_i = 1; MemRead_i = 1; MemWrite_i = 0; funct3_i = 3'd2; ALUResult_i = 32'h300;
        RDaddr_i = 5'd12; RegWrite_i = 1; MemtoReg_i = 1; mem_ack_i = 0;
        #1;
        chk("rb_idle_stall", 32'(stall_o), 32'h1);
        @(negedge clk_i);
        #1;
        chk("rb_busy_req", 32'(mem_req_o), 32'h1);
        @(negedge clk_i);
        rst_i = 1; valid_i = 0; MemRead_i = 0; RegWrite_i = 0; MemtoReg_i = 0;
        @(negedge clk_i);
        rst_i = 0; mem_ack_i = 1; mem_rdata_i = 32'h1111_2222;
        #1;
        chk("rb_req", 32'(mem_req_o), 32'h0);
        chk("rb_stall", 32'(stall_o), 32'h0);
        chk("rb_err", 32'(err_o), 32'h0);
        chk("rb_mem_o", mem_o, 32'h0);
        @(negedge clk_i);
        mem_ack_i = 0;
        #1;
        chk("rb_after_req", 32'(mem_req_o), 32'h0);
        chk("rb_after_stall", 32'(stall_o), 32'h0);
        chk("rb_after_mem_o", mem_o, 32'h0);
        chk("rb_after_rw", 32'(RegWrite_o), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 3);
            vld  = ($urandom_range(0, 7) != 0);
            rd_en = (kind == 1) || (kind == 3);
            wr_en = (kind == 2) || (kind == 3);
            if ($urandom_range(0, 3) != 0) f3 = legal_f3[$urandom_range(0, 4)];
            else                           f3 = 3'($urandom_range(0, 7));
            do_op(vld, rd_en, wr_en, f3, $urandom, $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 5), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
